// File: rtl/risc16_alu_pkg.sv
// risc16_alu_pkg: shared ALU constants (function-code width, function codes, default word length)
package risc16_alu_pkg;
  localparam int DEF_WORD_LENGTH = 16;
  localparam int ALU_FUNCT_LEN = 3;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_NAND  = 3'b010;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASS1 = 3'b011;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASS2 = 3'b100;
  localparam logic [ALU_FUNCT_LEN-1:0] ALU_EQ    = 3'b101;
endpackage

// File: rtl/risc16_alu_core.sv
// risc16_alu_core: combinational operation mux; ports: src1/src2 operands, funct select, next_result, next_state (zero flag)
module risc16_alu_core
  import risc16_alu_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH
) (
  input  logic [WORD_LENGTH-1:0]   src1,
  input  logic [WORD_LENGTH-1:0]   src2,
  input  logic [ALU_FUNCT_LEN-1:0] funct,
  output logic [WORD_LENGTH-1:0]   next_result,
  output logic                     next_state
);
  logic [WORD_LENGTH-1:0] eq_word;
  assign eq_word = {{(WORD_LENGTH-1){1'b0}}, src1 == src2};
  always_comb begin
    next_result = funct == ALU_ADD   ? src1 + src2 :
                  funct == ALU_SUB   ? src1 - src2 :
                  funct == ALU_NAND  ? ~(src1 & src2) :
                  funct == ALU_PASS1 ? src1 :
                  funct == ALU_PASS2 ? src2 :
                  funct == ALU_EQ    ? eq_word : '0;
    next_state = ~|next_result;
  end
endmodule

// File: rtl/risc16_alu.sv
// risc16_alu: registered RiSC-16 ALU; ports: clk, rst_n (async low), src1/src2, funct, in_valid -> result, state (zero flag), out_valid
module risc16_alu
  import risc16_alu_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WORD_LENGTH-1:0]   src1,
  input  logic [WORD_LENGTH-1:0]   src2,
  input  logic [ALU_FUNCT_LEN-1:0] funct,
  input  logic                     in_valid,
  output logic [WORD_LENGTH-1:0]   result,
  output logic                     state,
  output logic                     out_valid
);
  logic [WORD_LENGTH-1:0] next_result;
  logic                   next_state;
  risc16_alu_core #(.WORD_LENGTH(WORD_LENGTH)) u_core (
    .src1(src1),
    .src2(src2),
    .funct(funct),
    .next_result(next_result),
    .next_state(next_state)
  );
  // result/state load only on valid, so X operands on idle cycles never reach them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      state     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= next_result;
        state  <= next_state;
      end
    end
  end
endmodule

// File: tb/tb_risc16_alu.sv
// tb_risc16_alu: directed scoreboard bench for risc16_alu
module tb_risc16_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] src1 = '0;
  logic [15:0] src2 = '0;
  logic [2:0]  funct = '0;
  logic        in_valid = 1'b0;
  logic [15:0] result;
  logic        state;
  logic        out_valid;
  int vectors = 0;
  int errs = 0;
  typedef struct {
    logic        v;
    logic [15:0] r;
    logic        s;
  } exp_t;
  exp_t q[$];
  logic [15:0] mr = '0;
  logic        ms = 1'b0;
  risc16_alu dut (
    .clk(clk),
    .rst_n(rst_n),
    .src1(src1),
    .src2(src2),
    .funct(funct),
    .in_valid(in_valid),
    .result(result),
    .state(state),
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~(a & b);
      3'd3: return a;
      3'd4: return b;
      3'd5: return (a == b) ? 16'h0001 : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction
  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      errs++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = q.pop_front();
      cmp({tag, ".out_valid"}, {15'b0, out_valid}, {15'b0, e.v});
      cmp({tag, ".result"}, result, e.r);
      cmp({tag, ".state"}, {15'b0, state}, {15'b0, e.s});
    end
  endtask
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [2:0] f, input logic v);
    src1 = a;
    src2 = b;
    funct = f;
    in_valid = v;
    if (v) begin
      mr = model(a, b, f);
      ms = (mr == 16'h0000);
    end
    q.push_back('{v, mr, ms});
    @(posedge clk);
    #1;
    check(tag);
  endtask
  initial begin
    src1 = 16'h1234;
    src2 = 16'h4321;
    funct = 3'd0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    q.push_back('{1'b0, 16'h0000, 1'b0});
    check("reset");
    rst_n = 1'b1;
    step("add", 16'h1111, 16'heaaa, 3'd0, 1'b1);
    step("sub_eq", 16'h2222, 16'h2222, 3'd1, 1'b1);
    step("sub_ne", 16'h2222, 16'h2223, 3'd1, 1'b1);
    step("add_wrap", 16'hffff, 16'h0001, 3'd0, 1'b1);
    step("nand", 16'hffff, 16'h00ff, 3'd2, 1'b1);
    step("pass1", 16'h8001, 16'h7777, 3'd3, 1'b1);
    step("pass2", 16'h5555, 16'hffc0, 3'd4, 1'b1);
    step("eq_t", 16'h1234, 16'h1234, 3'd5, 1'b1);
    step("eq_f", 16'h1234, 16'h1235, 3'd5, 1'b1);
    step("nand_zero", 16'hffff, 16'hffff, 3'd2, 1'b1);
    step("code6", 16'habcd, 16'h1357, 3'd6, 1'b1);
    step("pass1_b", 16'hbeef, 16'h0000, 3'd3, 1'b1);
    step("idle_hold", 16'hxxxx, 16'hxxxx, 3'bxxx, 1'b0);
    step("code7", 16'h0f0f, 16'hf0f0, 3'd7, 1'b1);
    step("sub_b2b", 16'h0000, 16'h0001, 3'd1, 1'b1);
    step("add_b2b", 16'h7fff, 16'h0001, 3'd0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    mr = 16'h0000;
    ms = 1'b0;
    q.push_back('{1'b0, 16'h0000, 1'b0});
    check("async_rst");
    #2;
    rst_n = 1'b1;
    step("post_rst_idle", 16'hxxxx, 16'hxxxx, 3'bxxx, 1'b0);
    step("post_rst_add", 16'h0102, 16'h0304, 3'd0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
